// File: rtl/pll_seq_pkg.sv
// Shared types and elaboration helpers for the PLL reset sequencer.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      PWRUP     = 3'd3,
      RUN       = 3'd4
   } seq_state_t;

   localparam int LOSS_CNT_MAX = 255;

   // A down-counter loaded with cycles-1 needs clog2(cycles) bits.
   function automatic bit cnt_w_fits(input int cnt_w, input int cycles);
      return (cycles <= 1) || (cnt_w >= $clog2(cycles));
   endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop single-bit synchronizer, reset to 0; latency SYNC_STAGES clocks, no backpressure.
module sync_bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      end
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses PLL reset, qualifies lock, waits out SDRAM power-up, then releases system reset.
// sys_rst_n rises SYNC_STAGES+LOCK_STABLE_CYCLES+PWRUP_CYCLES edges after the edge that first samples pll_locked high; no backpressure.
module pll_reset_sequencer #(
   parameter int SYNC_STAGES        = 2,
   parameter int PLL_RST_CYCLES     = 16,
   parameter int LOCK_TIMEOUT       = 65536,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int PWRUP_CYCLES       = 10000,
   parameter int CNT_W              = 17
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       sdram_pwrup_done,
   output logic [7:0] lock_loss_cnt,
   output logic [2:0] seq_state
);

   import pll_seq_pkg::*;

   localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CD = (LOCK_STABLE_CYCLES > PWRUP_CYCLES) ? LOCK_STABLE_CYCLES : PWRUP_CYCLES;
   localparam int MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;

   if (SYNC_STAGES < 2) begin : g_sync_check
      $error("pll_reset_sequencer: SYNC_STAGES must be at least 2");
   end
   if (!cnt_w_fits(CNT_W, MAX_CYCLES)) begin : g_cnt_check
      $error("pll_reset_sequencer: CNT_W too narrow for the cycle parameters");
   end

   localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STB_LOAD = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] PW_LOAD  = CNT_W'(PWRUP_CYCLES - 1);

   seq_state_t       state_q;
   seq_state_t       state_nxt;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_nxt;
   logic             cnt_zero;
   logic             loss_evt;
   logic             locked_s;
   logic             pll_rst_nxt;
   logic             run_nxt;

   sync_bit #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_lock_sync (
      .clk  (refclk),
      .rst_n(rst_n),
      .d    (pll_locked),
      .q    (locked_s)
   );

   assign cnt_zero  = (cnt_q == '0);
   assign seq_state = state_q;

   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         state_q          <= PLL_RST;
         cnt_q            <= RST_LOAD;
         lock_loss_cnt    <= '0;
         pll_rst          <= 1'b1;
         sys_rst_n        <= 1'b0;
         sdram_pwrup_done <= 1'b0;
      end else begin
         state_q          <= state_nxt;
         cnt_q            <= cnt_nxt;
         pll_rst          <= pll_rst_nxt;
         sys_rst_n        <= run_nxt;
         sdram_pwrup_done <= run_nxt;
         if (loss_evt && (lock_loss_cnt != 8'(LOSS_CNT_MAX))) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
         end
      end
   end

   // Lock checks come before counter expiry so a drop on the last cycle is never missed.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      loss_evt  = 1'b0;
      case (state_q)
         PLL_RST: begin
            if (cnt_zero) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = TO_LOAD;
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               state_nxt = STABLE;
               cnt_nxt   = STB_LOAD;
            end else if (cnt_zero) begin
               state_nxt = PLL_RST;
               cnt_nxt   = RST_LOAD;
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         STABLE: begin
            if (!locked_s) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = TO_LOAD;
            end else if (cnt_zero) begin
               state_nxt = PWRUP;
               cnt_nxt   = PW_LOAD;
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         PWRUP: begin
            if (!locked_s) begin
               state_nxt = PLL_RST;
               cnt_nxt   = RST_LOAD;
               loss_evt  = 1'b1;
            end else if (cnt_zero) begin
               state_nxt = RUN;
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         RUN: begin
            if (!locked_s) begin
               state_nxt = PLL_RST;
               cnt_nxt   = RST_LOAD;
               loss_evt  = 1'b1;
            end
         end
         default: begin
            state_nxt = PLL_RST;
            cnt_nxt   = RST_LOAD;
         end
      endcase
   end

   always_comb begin
      pll_rst_nxt = (state_nxt == PLL_RST);
      run_nxt     = (state_nxt == RUN);
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: vector table, directed corner sequences, randomized run vs model.
module tb_pll_reset_sequencer;

   localparam int SS  = 2;
   localparam int PR  = 4;
   localparam int LT  = 32;
   localparam int LS  = 8;
   localparam int PW  = 20;
   localparam int LAT = SS + LS + PW;

   logic       refclk     = 1'b0;
   logic       rst_n      = 1'b0;
   logic       pll_locked = 1'b0;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       sdram_pwrup_done;
   logic [7:0] lock_loss_cnt;
   logic [2:0] seq_state;

   int total = 0;
   int bad   = 0;

   always #10 refclk = ~refclk;

   pll_reset_sequencer #(
      .SYNC_STAGES       (SS),
      .PLL_RST_CYCLES    (PR),
      .LOCK_TIMEOUT      (LT),
      .LOCK_STABLE_CYCLES(LS),
      .PWRUP_CYCLES      (PW),
      .CNT_W             (17)
   ) dut (
      .refclk          (refclk),
      .rst_n           (rst_n),
      .pll_locked      (pll_locked),
      .pll_rst         (pll_rst),
      .sys_rst_n       (sys_rst_n),
      .sdram_pwrup_done(sdram_pwrup_done),
      .lock_loss_cnt   (lock_loss_cnt),
      .seq_state       (seq_state)
   );

   // Reference model: phase plus cycles-elapsed-in-phase, lock seen through a plain delay line.
   int m_ph  = 0;
   int m_el  = 0;
   int m_cnt = 0;
   bit m_ls;
   bit m_loss;
   bit m_q[$];

   always @(posedge refclk) begin
      if (!rst_n) begin
         m_ph = 0; m_el = 0; m_cnt = 0;
         m_q.delete();
         for (int i = 0; i < SS; i++) m_q.push_back(1'b0);
      end else begin
         m_ls = m_q.pop_front();
         m_q.push_back(pll_locked);
         m_loss = 1'b0;
         case (m_ph)
            0: if (m_el == PR - 1) begin m_ph = 1; m_el = 0; end else m_el++;
            1: if (m_ls) begin m_ph = 2; m_el = 0; end
               else if (m_el == LT - 1) begin m_ph = 0; m_el = 0; end
               else m_el++;
            2: if (!m_ls) begin m_ph = 1; m_el = 0; end
               else if (m_el == LS - 1) begin m_ph = 3; m_el = 0; end
               else m_el++;
            3: if (!m_ls) m_loss = 1'b1;
               else if (m_el == PW - 1) begin m_ph = 4; m_el = 0; end
               else m_el++;
            default: if (!m_ls) m_loss = 1'b1;
         endcase
         if (m_loss) begin
            m_ph = 0; m_el = 0;
            if (m_cnt < 255) m_cnt++;
         end
      end
   end

   function automatic logic [13:0] m_exp();
      return {m_ph == 0, m_ph == 4, m_ph == 4, 3'(m_ph), 8'(m_cnt)};
   endfunction

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_state(input logic [2:0] st, input int budget, input string name);
      int n = 0;
      while (seq_state !== st && n < budget) begin
         tick();
         n++;
      end
      chk(name, 32'(seq_state), 32'(st));
   endtask

   typedef struct {
      logic       rst_n;
      logic       locked;
      int         ncyc;
      logic       e_pll_rst;
      logic       e_sys_rst_n;
      logic [2:0] e_state;
      logic [7:0] e_cnt;
   } vec_t;

   vec_t tbl[5];
   int   n;
   bit   ok;

   initial begin
      tbl[0] = '{1'b0, 1'b0, 3,  1'b1, 1'b0, 3'd0, 8'd0};
      tbl[1] = '{1'b1, 1'b0, 3,  1'b1, 1'b0, 3'd0, 8'd0};
      tbl[2] = '{1'b1, 1'b0, LT, 1'b0, 1'b0, 3'd1, 8'd0};
      tbl[3] = '{1'b1, 1'b0, PR, 1'b1, 1'b0, 3'd0, 8'd0};
      tbl[4] = '{1'b1, 1'b0, 2,  1'b0, 1'b0, 3'd1, 8'd0};

      // Power-on with no lock: reset pulse, timeout window, re-pulse.
      for (int r = 0; r < 5; r++) begin
         rst_n      = tbl[r].rst_n;
         pll_locked = tbl[r].locked;
         for (int c = 0; c < tbl[r].ncyc; c++) begin
            tick();
            chk($sformatf("por%0d_pll_rst", r), 32'(pll_rst), 32'(tbl[r].e_pll_rst));
            chk($sformatf("por%0d_sys_rst_n", r), 32'(sys_rst_n), 32'(tbl[r].e_sys_rst_n));
            chk($sformatf("por%0d_done", r), 32'(sdram_pwrup_done), 32'(tbl[r].e_sys_rst_n));
            chk($sformatf("por%0d_state", r), 32'(seq_state), 32'(tbl[r].e_state));
            chk($sformatf("por%0d_loss", r), 32'(lock_loss_cnt), 32'(tbl[r].e_cnt));
         end
      end

      // Clean lock during the first WAIT_LOCK after reset; measure release latency.
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      wait_state(3'd1, 20, "first_wait");
      pll_locked = 1'b1;
      n  = 0;
      ok = 1'b1;
      do begin
         tick();
         n++;
         if (sdram_pwrup_done !== sys_rst_n) ok = 1'b0;
      end while (sys_rst_n !== 1'b1 && n < 200);
      chk("lock_latency", 32'(n - 1), 32'(LAT));
      chk("done_tracks_sysrst", 32'(ok), 32'd1);
      ok = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (!(sys_rst_n === 1'b1 && sdram_pwrup_done === 1'b1)) ok = 1'b0;
      end
      chk("run_holds", 32'(ok), 32'd1);

      // Lock loss in RUN: two-cycle sync delay, then a full PLL reset pulse.
      pll_locked = 1'b0;
      tick(); chk("loss_k0_state", 32'(seq_state), 32'd4);
      tick(); chk("loss_k1_sysrst", 32'(sys_rst_n), 32'd1);
      tick();
      chk("loss_pll_rst", 32'(pll_rst), 32'd1);
      chk("loss_sys_rst_n", 32'(sys_rst_n), 32'd0);
      chk("loss_done", 32'(sdram_pwrup_done), 32'd0);
      chk("loss_state", 32'(seq_state), 32'd0);
      chk("loss_cnt1", 32'(lock_loss_cnt), 32'd1);
      n = 1;
      while (pll_rst === 1'b1 && n < 20) begin
         tick();
         if (pll_rst === 1'b1) n++;
      end
      chk("loss_pll_rst_len", 32'(n), 32'(PR));
      pll_locked = 1'b1;
      wait_state(3'd4, 80, "loss_relock");
      chk("loss_cnt_after_relock", 32'(lock_loss_cnt), 32'd1);

      // Glitch in STABLE after 5 stable cycles: back to WAIT_LOCK, stable count restarts.
      pll_locked = 1'b0;
      wait_state(3'd0, 20, "glitch_prep_drop");
      pll_locked = 1'b1;
      wait_state(3'd2, 40, "glitch_prep_stable");
      repeat (4) tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      wait_state(3'd1, 10, "glitch_to_wait");
      chk("glitch_not_counted", 32'(lock_loss_cnt), 32'd2);
      wait_state(3'd2, 10, "glitch_restable");
      n  = 0;
      ok = 1'b1;
      while (seq_state !== 3'd3 && n < 50) begin
         tick();
         n++;
         if (sys_rst_n !== 1'b0) ok = 1'b0;
      end
      chk("glitch_stable_restart", 32'(n), 32'(LS));
      chk("glitch_sysrst_low", 32'(ok), 32'd1);

      // Lock drop seen exactly when the PWRUP counter expires: loss wins over RUN.
      repeat (PW - 3) tick();
      pll_locked = 1'b0;
      tick();
      tick(); chk("pwrup_corner_hold", 32'(seq_state), 32'd3);
      tick();
      chk("pwrup_corner_state", 32'(seq_state), 32'd0);
      chk("pwrup_corner_cnt", 32'(lock_loss_cnt), 32'd3);
      chk("pwrup_corner_sysrst", 32'(sys_rst_n), 32'd0);
      pll_locked = 1'b1;
      wait_state(3'd4, 80, "pwrup_corner_relock");

      // Saturation: 257 more losses in RUN, 260 in total.
      for (int i = 0; i < 257; i++) begin
         pll_locked = 1'b0;
         wait_state(3'd0, 20, "sat_drop");
         pll_locked = 1'b1;
         wait_state(3'd4, 80, "sat_relock");
         if (i == 251) chk("sat_reach_255", 32'(lock_loss_cnt), 32'd255);
      end
      chk("sat_hold_255", 32'(lock_loss_cnt), 32'd255);

      // Reset applied mid-PWRUP.
      pll_locked = 1'b0;
      wait_state(3'd0, 20, "rst_prep_drop");
      pll_locked = 1'b1;
      wait_state(3'd3, 40, "rst_prep_pwrup");
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_pll_rst", 32'(pll_rst), 32'd1);
      chk("midrst_state", 32'(seq_state), 32'd0);
      chk("midrst_cnt", 32'(lock_loss_cnt), 32'd0);
      chk("midrst_sys_rst_n", 32'(sys_rst_n), 32'd0);
      chk("midrst_done", 32'(sdram_pwrup_done), 32'd0);

      // Randomized lock behaviour and occasional resets against the model.
      n = 0;
      while (n < 3000) begin
         int len;
         pll_locked = ($urandom_range(0, 2) != 0);
         len = pll_locked ? $urandom_range(1, 80) : $urandom_range(1, 45);
         for (int k = 0; k < len; k++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
            n++;
            chk("model", 32'({pll_rst, sys_rst_n, sdram_pwrup_done, seq_state, lock_loss_cnt}),
                32'(m_exp()));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
